// File: rtl/pc_unit_ras_if.sv
// Control/status bundle between the control unit and the PC unit.
// The master side drives the control requests. The slave side (the PC unit)
// returns the current PC and the return-address stack status.
interface pc_unit_ras_if #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned OFF_W     = 8,
    parameter int unsigned RAS_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              hlt;
    logic              resume;
    logic              stall;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              br_taken;
    logic [OFF_W-1:0]  br_off;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc_out;
    logic              halted;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_ovf;
    logic              ras_unf;

    modport master (
        output hlt, resume, stall, jump, jump_addr, br_taken, br_off, call, ret,
        input  pc_out, halted, ras_count, ras_ovf, ras_unf
    );

    modport slave (
        input  hlt, resume, stall, jump, jump_addr, br_taken, br_off, call, ret,
        output pc_out, halted, ras_count, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_unit_ras.sv
// Program-counter unit with a halt/resume FSM and a circular return-address stack.
// It supports stall, return, call, jump and branch requests, in that priority order.
module pc_unit_ras #(
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          OFF_W     = 8,
    parameter int unsigned          STEP      = 1,
    parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
    parameter int unsigned          RAS_DEPTH = 8
) (
    input logic          clock,
    input logic          reset,
    pc_unit_ras_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    typedef enum logic [0:0] {StRun, StHalted} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    // top_q points at the slot the next push writes. The newest entry is at top_q-1.
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_ext;

    assign pc_inc = pc_q + ADDR_W'(STEP);
    assign br_ext = {{(ADDR_W - OFF_W){bus.br_off[OFF_W-1]}}, bus.br_off};

    // Next-state and next-PC selection. Only one action is taken per edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.hlt) begin
                    state_d = StHalted;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.ret) begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_mem[top_q - PTR_W'(1)];
                        top_d = top_q - PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end
                end else if (bus.call) begin
                    push  = 1'b1;
                    pc_d  = bus.jump_addr;
                    top_d = top_q + PTR_W'(1);
                    // When the stack is full, the push wraps onto the oldest entry.
                    if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (bus.jump) begin
                    pc_d = bus.jump_addr;
                end else if (bus.br_taken) begin
                    pc_d = pc_q + br_ext;
                end else begin
                    pc_d = pc_inc;
                end
            end
            StHalted: begin
                if (bus.resume) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // State, PC, pointer and sticky-flag registers, with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= RESET_VEC;
            top_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage write. The contents are don't-care after reset, so there is no reset term.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            ras_mem[top_q] <= pc_inc;
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.halted    = (state_q == StHalted);
    assign bus.ras_count = cnt_q;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras. It runs directed scenarios followed by
// randomized traffic. All results are compared against a queue-based reference model.
module tb_pc_unit_ras;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned OFF_W  = 8;
    localparam int unsigned DEPTH  = 8;
    localparam logic [15:0] RV     = 16'h0100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pc_unit_ras_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH)) bus ();

    pc_unit_ras #(
        .ADDR_W(ADDR_W), .OFF_W(OFF_W), .STEP(1), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference model state.
    logic [15:0] m_pc;
    bit          m_halted;
    bit          m_ovf;
    bit          m_unf;
    logic [15:0] m_ras[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.hlt = 0; bus.resume = 0; bus.stall = 0; bus.jump = 0; bus.jump_addr = '0;
        bus.br_taken = 0; bus.br_off = '0; bus.call = 0; bus.ret = 0;
    endtask

    // Applies the architectural rules to the current inputs.
    task automatic model_step();
        if (reset) begin
            m_pc = RV; m_halted = 0; m_ovf = 0; m_unf = 0; m_ras.delete();
        end else if (m_halted) begin
            if (bus.resume) m_halted = 0;
        end else if (bus.hlt) begin
            m_halted = 1;
        end else if (bus.stall) begin
            m_pc = m_pc;
        end else if (bus.ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
                m_pc = m_pc + 16'd1;
                m_unf = 1;
            end
        end else if (bus.call) begin
            m_ras.push_back(m_pc + 16'd1);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1;
            end
            m_pc = bus.jump_addr;
        end else if (bus.jump) begin
            m_pc = bus.jump_addr;
        end else if (bus.br_taken) begin
            m_pc = 16'(int'(m_pc) + int'($signed(bus.br_off)));
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    // Advances one clock cycle and compares every output against the model.
    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        check("pc_out", 32'(bus.pc_out), 32'(m_pc));
        check("halted", 32'(bus.halted), 32'(m_halted));
        check("ras_count", 32'(bus.ras_count), 32'(m_ras.size()));
        check("ras_ovf", 32'(bus.ras_ovf), 32'(m_ovf));
        check("ras_unf", 32'(bus.ras_unf), 32'(m_unf));
    endtask

    task automatic do_jump(input logic [15:0] a);
        idle(); bus.jump = 1; bus.jump_addr = a; cyc(); idle();
    endtask

    task automatic do_call(input logic [15:0] a);
        idle(); bus.call = 1; bus.jump_addr = a; cyc(); idle();
    endtask

    task automatic do_ret();
        idle(); bus.ret = 1; cyc(); idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1;
        cyc();
        reset = 0;
        check("reset_pc", 32'(bus.pc_out), 32'h0100);
        check("reset_halted", 32'(bus.halted), 32'h0);
        check("reset_cnt", 32'(bus.ras_count), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("free_run", 32'(bus.pc_out), 32'h0100 + 32'(i));
        end

        // Halt and resume.
        do_jump(16'h0010);
        bus.hlt = 1; cyc(); idle();
        check("halt_enter", 32'(bus.halted), 32'h1);
        check("halt_pc", 32'(bus.pc_out), 32'h0010);
        for (int i = 0; i < 5; i++) cyc();
        do_jump(16'h0555);
        check("halt_ignores_jump", 32'(bus.pc_out), 32'h0010);
        bus.resume = 1; cyc(); idle();
        check("resume_halted", 32'(bus.halted), 32'h0);
        check("resume_pc", 32'(bus.pc_out), 32'h0010);
        cyc();
        check("after_resume", 32'(bus.pc_out), 32'h0011);

        // Branches, including wrap-around.
        do_jump(16'h0020);
        bus.br_taken = 1; bus.br_off = 8'hFC; cyc(); idle();
        check("br_neg", 32'(bus.pc_out), 32'h001C);
        do_jump(16'hFFFE);
        bus.br_taken = 1; bus.br_off = 8'h05; cyc(); idle();
        check("br_wrap", 32'(bus.pc_out), 32'h0003);

        // Nested calls and underflow.
        do_jump(16'h0010);
        do_call(16'h0200);
        cyc();
        do_call(16'h0300);
        check("nest_cnt", 32'(bus.ras_count), 32'h2);
        do_ret();
        check("ret1", 32'(bus.pc_out), 32'h0202);
        do_ret();
        check("ret2", 32'(bus.pc_out), 32'h0011);
        do_ret();
        check("unf_flag", 32'(bus.ras_unf), 32'h1);
        check("unf_pc", 32'(bus.pc_out), 32'h0012);

        // Overflow: 9 calls, then 8 returns.
        reset = 1; cyc(); reset = 0;
        do_jump(16'h0000);
        for (int i = 0; i < 9; i++) do_call(16'(i + 1));
        check("ovf_flag", 32'(bus.ras_ovf), 32'h1);
        check("ovf_cnt", 32'(bus.ras_count), 32'h8);
        for (int i = 0; i < 8; i++) begin
            do_ret();
            check("ovf_ret", 32'(bus.pc_out), 32'h0009 - 32'(i));
        end

        // Request priority.
        do_call(16'h0400);
        bus.stall = 1; bus.ret = 1; bus.call = 1; bus.jump = 1; bus.jump_addr = 16'h0700;
        cyc(); idle();
        check("prio_stall", 32'(bus.pc_out), 32'h0400);
        bus.ret = 1; bus.call = 1; bus.jump = 1; bus.jump_addr = 16'h0700;
        cyc(); idle();
        check("prio_ret", 32'(bus.pc_out), 32'h0003);

        // Reset while halted with three stacked entries.
        do_call(16'h0500);
        do_call(16'h0600);
        do_call(16'h0700);
        check("three_cnt", 32'(bus.ras_count), 32'h3);
        bus.hlt = 1; cyc(); idle();
        reset = 1; cyc(); reset = 0;
        check("rst_halt_pc", 32'(bus.pc_out), 32'h0100);
        check("rst_halt_cnt", 32'(bus.ras_count), 32'h0);
        check("rst_halt_ovf", 32'(bus.ras_ovf), 32'h0);
        check("rst_halt_unf", 32'(bus.ras_unf), 32'h0);
        check("rst_halt_halted", 32'(bus.halted), 32'h0);

        // Randomized traffic checked against the model.
        for (int n = 0; n < 2000; n++) begin
            reset        = ($urandom_range(0, 79) == 0);
            bus.hlt      = ($urandom_range(0, 11) == 0);
            bus.resume   = ($urandom_range(0, 2) == 0);
            bus.stall    = ($urandom_range(0, 7) == 0);
            bus.ret      = ($urandom_range(0, 3) == 0);
            bus.call     = ($urandom_range(0, 3) == 0);
            bus.jump     = ($urandom_range(0, 5) == 0);
            bus.br_taken = ($urandom_range(0, 3) == 0);
            bus.jump_addr = 16'($urandom);
            bus.br_off    = 8'($urandom);
            cyc();
        end
        reset = 0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised program-counter unit; the next generation of the core's PC register.
- Adds sequential increment, absolute jump, PC-relative branch, and call/return through an internal return-address stack (RAS).
- Adds an explicit halt/resume state machine and stall support.
- Sits between the control unit / branch logic and the instruction-memory address port.

Parameters:
- ADDR_W, 16, width of PC and all address ports.
- OFF_W, 8, width of signed branch offset.
- STEP, 1, increment applied on sequential advance.
- RESET_VEC, 0, PC value loaded on reset.
- RAS_DEPTH, 8, return-address stack entries; power of two, ≥2.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- hlt  in  1  request halt; enter HALTED at the next edge.
- resume  in  1  leave HALTED; ignored in RUN.
- stall  in  1  hold PC for this cycle; RUN only.
- jump  in  1  absolute jump to jump_addr.
- jump_addr  in  ADDR_W  jump/call target.
- br_taken  in  1  PC-relative branch.
- br_off  in  OFF_W  signed two's-complement branch offset.
- call  in  1  push pc+STEP, go to jump_addr.
- ret  in  1  pop RAS into PC.
- pc_out  out  ADDR_W  registered current PC.
- halted  out  1  1 while in HALTED state.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_ovf  out  1  sticky: call with RAS full.
- ras_unf  out  1  sticky: ret with RAS empty.

Behaviour:
- Reset (synchronous, active-high; clock is clock), overrides everything:
  - pc_out=RESET_VEC, state=RUN, halted=0.
  - ras_count=0, ras_ovf=0, ras_unf=0.
  - RAS contents don't-care.
- States:
  - RUN: hlt=1 → HALTED. PC is not updated on that edge; all other controls are ignored on that edge.
  - HALTED: PC, RAS and flags frozen. All controls except resume/reset are ignored. resume=1 → RUN; PC still unchanged on that edge. First PC update happens on the following edge.
  - hlt and resume together in RUN: hlt wins.
  - hlt and resume together in HALTED: resume wins (state RUN). hlt is then re-sampled on the next cycle.
- In RUN with hlt=0, exactly one action per edge, priority high→low:
  1. stall: hold PC, no RAS change.
  2. ret:
     - RAS non-empty: pc<=top entry, ras_count-1.
     - RAS empty: pc<=pc+STEP, ras_unf<=1, count stays 0.
  3. call:
     - Push pc+STEP, pc<=jump_addr, ras_count+1.
     - RAS full: overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_ovf<=1.
  4. jump: pc<=jump_addr.
  5. br_taken: pc<=pc+sign_extend(br_off).
  6. default: pc<=pc+STEP.
- Lower-priority requests asserted in the same cycle are dropped, not queued.
- Arithmetic: all PC sums are modulo 2^ADDR_W; wrap-around is silent, with no flag. Example (ADDR_W=16): 0xFFFF+1 → 0x0000; 0x0002+(-4) → 0xFFFE.
- RAS organisation:
  - Circular buffer with a top pointer; push/pop are single-cycle.
  - Pushed value is the pre-update pc_out+STEP.
  - Pop reads the entry pushed most recently among valid entries.
  - After an overflow, only the newest RAS_DEPTH return addresses are recoverable.
- Latency: all effects are visible on pc_out one cycle after the controlling edge. There is no combinational path from inputs to outputs.
- ras_ovf/ras_unf clear only on reset.

Test Plan:
- Reset then 4 free-running cycles, RESET_VEC=0x0100 → pc_out 0x0100, 0x0101, 0x0102, 0x0103, 0x0104; halted=0; ras_count=0.
- PC=0x0010. hlt for 1 cycle → halted=1, PC stays 0x0010 for 5 idle cycles. Assert jump during HALTED → ignored. resume → halted=0, PC 0x0010 on that edge, then 0x0011.
- PC=0x0020. Branch with br_off=0xFC → 0x001C. Branch at 0xFFFE with br_off=0x05 → 0x0003.
- Nested calls:
  - call 0x0200 at PC 0x0010, then call 0x0300 at PC 0x0201 → ras_count=2.
  - ret → 0x0202; ret → 0x0011; ret again → ras_unf=1, PC 0x0012.
- Call overflow, RAS_DEPTH=8: 9 calls from PCs 0x0000..0x0008 → ras_ovf=1, count=8. 8 rets return 0x0009..0x0002 in that order.
- Priority with stall, ret, call and jump all asserted → PC held. Then ret+call+jump → ret wins. Reset asserted while halted with RAS count 3 → PC=RESET_VEC, count 0, flags 0, halted=0.
